// File: rtl/glitch_pkg.sv
// Shared state encoding and default constants for the glitch_filter slice.
package glitch_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } gf_state_e;

  localparam int unsigned GF_STABLE_CYCLES_DEF = 4;
  localparam int unsigned GF_GCNT_W_DEF        = 8;

endpackage

// File: rtl/glitch_filter_sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser with a parameterised reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/glitch_filter.sv
// glitch_filter: passes a new input level only after STABLE_CYCLES matching samples.
// Build macro GLITCH_FILTER_SYNC_EN inserts a 2-flop synchroniser ahead of the filter.
//   state  | meaning
//   STABLE | sample agrees with out, nothing pending
//   CHECK  | candidate level being counted toward STABLE_CYCLES
module glitch_filter
  import glitch_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = GF_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1),
  parameter logic        RST_VAL       = 1'b0,
  parameter int unsigned GCNT_W        = GF_GCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_in,
  output logic              out,
  output logic              rise,
  output logic              fall,
  output logic              busy,
  output logic [GCNT_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [GCNT_W-1:0] GCNT_MAX = {GCNT_W{1'b1}};

  gf_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              out_q, out_d;
  logic              rise_q, fall_q;
  logic              sample;

`ifdef GLITCH_FILTER_SYNC_EN
  sync_2ff #(
    .RST_VAL(RST_VAL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (data_in),
    .q_o  (sample)
  );
`else
  assign sample = data_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      out_q   <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      out_q   <= out_d;
      rise_q  <= out_d & ~out_q;
      fall_q  <= ~out_d & out_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    out_d   = out_q;
    case (state_q)
      STABLE: begin
        if (sample == out_q) begin
          cnt_d = '0;
        end else if (STABLE_CYCLES == 1) begin
          out_d = sample;
        end else begin
          state_d = CHECK;
          cnt_d   = CNT_W'(1);
        end
      end
      CHECK: begin
        if (sample == out_q) begin
          // candidate fell back before qualifying: count it as a glitch
          state_d = STABLE;
          cnt_d   = '0;
          if (gcnt_q != GCNT_MAX) gcnt_d = gcnt_q + GCNT_W'(1);
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
          out_d   = sample;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out        = out_q;
    rise       = rise_q;
    fall       = fall_q;
    busy       = (state_q == CHECK);
    glitch_cnt = gcnt_q;
  end

endmodule

// File: doc/glitch_filter.md
Name: glitch_filter

Overview:
- Input deglitch/debounce filter: the output follows data_in only after data_in has held a new level for STABLE_CYCLES consecutive clock samples.
- It is the removal-side counterpart of the 3-flop pulse stretcher. The stretcher widens short pulses; this block rejects pulses shorter than STABLE_CYCLES.
- It sits on noisy single-bit inputs (buttons, external strobes, cross-board status) ahead of the control logic.
- It reports edge pulses and a saturating count of rejected glitches.

Parameters:
- STABLE_CYCLES, 4: consecutive differing samples required to flip out. Legal range 1..65535.
- CNT_W, $clog2(STABLE_CYCLES+1): width of the internal stability counter. Derived; do not override.
- RST_VAL, 1'b0: level of out and of the filter state after reset.
- GCNT_W, 8: width of glitch_cnt.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- data_in  input  1  raw input level, sampled on posedge.
- out  output  1  filtered level, registered.
- rise  output  1  one-cycle pulse in the same cycle out goes 0->1.
- fall  output  1  one-cycle pulse in the same cycle out goes 1->0.
- busy  output  1  high while a candidate transition is being qualified (state CHECK).
- glitch_cnt  output  GCNT_W  saturating count of rejected candidate transitions.

Behaviour:
- Reset values: out=RST_VAL, rise=0, fall=0, busy=0, glitch_cnt=0, state=STABLE, cnt=0. Reset mid-qualification discards the candidate; glitch_cnt is not incremented.
- Sample s = data_in at posedge. With the macro, s is the synchroniser output instead (see Optional Feature).
- FSM, two states:
  - STABLE:
    - s==out: stay, cnt=0.
    - s!=out and STABLE_CYCLES==1: flip out this edge; stay in STABLE.
    - s!=out and STABLE_CYCLES>1: go to CHECK with cnt=1.
  - CHECK:
    - s==out: reject the candidate. Go to STABLE, cnt=0, glitch_cnt+=1, saturating at all-ones.
    - s!=out and cnt==STABLE_CYCLES-1: flip out, go to STABLE, cnt=0.
    - s!=out otherwise: cnt+=1.
- Latency: data_in changes before edge k and holds. out is updated at edge k+STABLE_CYCLES-1 and visible after it. The macro adds 2 cycles.
- rise/fall are registered together with out: high for exactly the one cycle after the flipping edge, never both high. Back-to-back flips are separated by at least STABLE_CYCLES cycles.
- busy is high exactly when state==CHECK.
- A pulse of exactly STABLE_CYCLES-1 samples is rejected. A pulse of exactly STABLE_CYCLES samples passes.
- Wrap-around: cnt never exceeds STABLE_CYCLES-1. glitch_cnt saturates and never wraps.
- With STABLE_CYCLES==1, no glitch is ever counted.

Optional Feature:
- Macro: GLITCH_FILTER_SYNC_EN.
- Defined: data_in passes through a 2-flop synchroniser, both flops reset to RST_VAL, before the FSM. This makes data_in safe to drive from an asynchronous domain. Latency +2 cycles.
- Undefined: data_in is sampled directly and must be synchronous to clk.
- Filter behaviour is otherwise identical in both builds.

Decomposition:
- Shared package glitch_pkg holds:
  - state enum {STABLE, CHECK}
  - default constants for STABLE_CYCLES and GCNT_W
- Optional sub-module sync_2ff (width 1, parameterised reset value), instantiated only under GLITCH_FILTER_SYNC_EN. It is reusable elsewhere in the codebase.
- The FSM, counter and glitch counter stay in the top module.

Test Plan:
- Reset and idle: rst_n low 3 cycles, data_in=0 -> out=0, rise=fall=busy=0, glitch_cnt=0. Holding data_in=0 for 20 cycles produces no change.
- Valid rise, N=4: data_in 0->1 and held -> busy high for 3 cycles, out=1 after the 4th sample edge, rise high for exactly 1 cycle, glitch_cnt=0.
- Glitch rejection, N=4: 3-cycle high pulse on data_in -> out stays 0, busy high 3 cycles, glitch_cnt=1. Repeat 300 times -> glitch_cnt=255, saturated.
- Fall with boundary: out=1, 4-cycle low pulse -> out=0 for the duration, fall pulses once. Then data_in=1 held -> rise after 4 more cycles.
- Reset mid-operation: assert rst_n while busy=1 with cnt=2 -> out=RST_VAL immediately (async), cnt=0, glitch_cnt unchanged at 0. After release, normal qualification restarts.
- N=1 and sync build: STABLE_CYCLES=1 makes out follow data_in with 1-cycle latency and busy never high. With GLITCH_FILTER_SYNC_EN and N=4, a valid rise appears at out 6 cycles after the data_in change.
